des_ip_loader: RTL
==================

Name: des_ip_loader

Overview:
- Input-side front end of the DES datapath; the counterpart of the final-permutation (IP⁻¹) output stage.
- Accepts plaintext/ciphertext as a valid/ready byte stream and assembles 64-bit blocks.
- Applies the DES initial permutation IP to each block and presents L0/R0 to the round engine through a small output FIFO with valid/ready handshake.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥1).
- CNT_W, 16, width of the accepted-block counter.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  byte; first byte of a block = DES bits 1..8, MSB = bit 1.
- in_sof  input  1  first byte of a block; qualified by in_valid.
- in_valid  input  1  byte valid.
- in_ready  output  1  loader can accept a byte.
- out_l  output  32  L0 = IP output bits 1..32.
- out_r  output  32  R0 = IP output bits 33..64.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  round engine accepts head.
- blk_cnt  output  CNT_W  blocks pushed to FIFO since reset; wraps.
- sof_err  output  1  one-cycle pulse when a partial block is aborted by in_sof.

Behaviour:
- Reset values (async on rst high): byte counter 0, shift register 0, FIFO empty, out_valid 0, out_l/out_r 0, blk_cnt 0, sof_err 0. in_ready is 1 from the first cycle after rst falls.
- Byte accept: occurs when in_valid && in_ready. Byte k (0..7) fills DES bits 8k+1..8k+8.
- in_ready = (cnt != 7) || !fifo_full. It is registered-state-derived only, with no combinational path from out_ready.
- in_sof:
  - Accepted with cnt == 0: normal.
  - Accepted with cnt != 0: discards the partial block, pulses sof_err, and the byte becomes byte 0.
  - A byte accepted without in_sof at cnt == 0 is also legal; in_sof is only a resynchronisation aid.
- On accepting byte 7:
  - The assembled 64-bit block passes through combinational IP (standard table: out[1]=in[58], out[2]=in[50], …, out[64]=in[7]).
  - The result is written into the FIFO tail; cnt returns to 0; blk_cnt increments modulo 2^CNT_W.
- Latency: out_valid rises the cycle after byte 7 is accepted, when the FIFO was empty.
- FIFO:
  - Head visible on out_l/out_r when out_valid = 1.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop when full is not possible, because in_ready blocks byte 7.
  - Simultaneous push and pop when non-full keeps occupancy unchanged.
  - Head data is held stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH. An occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- rst mid-block: the partial block is lost and FIFO contents are discarded.
- Bytes 0–6 are always accepted regardless of FIFO state, to allow overlap of assembly with back-pressure.

Optional Feature:
- Macro: DES_IP_LOADER_BYPASS_EN.
- When defined: adds input bypass_ip (1 bit), sampled at byte-7 acceptance. If 1, the block is stored unpermuted (out_l = bits 1..32, out_r = bits 33..64), for datapath debug/known-answer tests.
- When undefined: the port is absent and IP is always applied.

Decomposition:
- Shared package des_pkg holds:
  - the IP table as a constant array of 64 indices (shared with the IP⁻¹ stage);
  - the des_block_t (64-bit) and des_half_t (32-bit) typedefs;
  - the constant BLOCK_BYTES = 8.
- One natural sub-module, des_ip_perm: purely combinational 64-bit IP driven from the package table, instantiated once before the FIFO write port.

Test Plan:
- Known-answer: bytes 01 23 45 67 89 AB CD EF with sof on the first byte → one beat, out_l = CC00CCFF, out_r = F0AAF0AA, blk_cnt = 1.
- Single-bit mapping: block 0x0000000000000040 (DES bit 58) → out_l = 80000000, out_r = 00000000. Block 0x0200000000000000 (bit 7) → out_l = 0, out_r = 00000001.
- Back-pressure (DEPTH=2, out_ready held 0): three blocks streamed.
  - The first two blocks fill the FIFO.
  - The third block's bytes 0–6 are accepted, then in_ready drops at cnt = 7.
  - Raising out_ready pops the heads in order, then in_ready returns and the third block arrives intact.
- Abort: 3 bytes, then in_sof with 8 fresh bytes → sof_err pulses exactly once, and exactly one block is output, built from the fresh bytes only.
- Reset mid-operation: rst asserted after 5 bytes with one block in the FIFO → out_valid = 0 immediately (async), blk_cnt = 0. The next full block after release is output correctly.
- Bypass (macro defined, bypass_ip = 1): 0123456789ABCDEF → out_l = 01234567, out_r = 89ABCDEF.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: block/half typedefs, block size and the initial-permutation table.
package des_pkg;

    typedef logic [63:0] des_block_t;
    typedef logic [31:0] des_half_t;

    localparam int unsigned BLOCK_BYTES = 8;

    // IP_TABLE[i] = 1-based DES input bit feeding output bit i+1 (DES bit 1 = vector MSB).
    localparam int unsigned IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

endpackage

// File: rtl/des_ip_perm.sv
// Purely combinational DES initial permutation driven from the shared table.
module des_ip_perm
    import des_pkg::*;
(
    input  des_block_t blk_i,
    output des_block_t blk_o
);

    always_comb begin
        blk_o = '0;
        for (int i = 0; i < 64; i++) begin
            blk_o[63 - i] = blk_i[64 - IP_TABLE[i]];
        end
    end

endmodule

// File: rtl/des_ip_loader.sv
// DES input front end: byte assembly, IP and output FIFO.
// Optional DES_IP_LOADER_BYPASS_EN adds bypass_ip to store blocks unpermuted.
module des_ip_loader
    import des_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_sof,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_l,
    output logic [31:0]      out_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             sof_err
`ifdef DES_IP_LOADER_BYPASS_EN
    ,
    input  logic             bypass_ip
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OccW = $clog2(DEPTH) + 1;

    logic [2:0]       cnt_q, cnt_d;
    des_block_t       shreg_q, shreg_d;
    des_block_t       mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0] blk_cnt_q;
    logic             sof_err_q;

    logic       accept, abort, push, pop, full, bypass;
    des_block_t block, block_ip, wdata;

`ifdef DES_IP_LOADER_BYPASS_EN
    assign bypass = bypass_ip;
`else
    assign bypass = 1'b0;
`endif

    assign full     = (occ_q == OccW'(DEPTH));
    assign in_ready = (cnt_q != 3'd7) || !full;
    assign accept   = in_valid && in_ready;
    assign abort    = accept && in_sof && (cnt_q != 3'd0);
    assign push     = accept && !abort && (cnt_q == 3'd7);
    assign out_valid = (occ_q != '0);
    assign pop      = out_valid && out_ready;

    assign block = {shreg_q[55:0], in_data};

    des_ip_perm u_ip_perm (
        .blk_i (block),
        .blk_o (block_ip)
    );

    assign wdata = bypass ? block : block_ip;

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (accept) begin
            if (abort) begin
                // Aborting byte restarts assembly as byte 0.
                cnt_d   = 3'd1;
                shreg_d = {56'b0, in_data};
            end else begin
                cnt_d   = cnt_q + 3'd1;
                shreg_d = block;
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            shreg_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            blk_cnt_q <= '0;
            sof_err_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            occ_q     <= occ_d;
            sof_err_q <= abort;
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q  <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
                blk_cnt_q <= blk_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
        end
    end

    assign out_l   = mem_q[rd_ptr_q][63:32];
    assign out_r   = mem_q[rd_ptr_q][31:0];
    assign blk_cnt = blk_cnt_q;
    assign sof_err = sof_err_q;

endmodule
